// File: rtl/vga_timing_pkg.sv
// Shared timing constants and types for the VGA timing generator.
// Defaults describe 640x480@60 with a 25 MHz pixel clock derived from 50 MHz.
package vga_timing_pkg;

  localparam int CNT_W = 11;

  localparam int DEF_CLK_DIV = 2;

  localparam int DEF_H_DISP = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;

  localparam int DEF_V_DISP = 480;
  localparam int DEF_V_FP   = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;

  localparam bit DEF_H_POL = 1'b0;
  localparam bit DEF_V_POL = 1'b0;

  function automatic int axis_total(input int disp, input int fp, input int sync, input int bp);
    return disp + fp + sync + bp;
  endfunction

  localparam int H_TOTAL = axis_total(DEF_H_DISP, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int V_TOTAL = axis_total(DEF_V_DISP, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

  // PARKED: counters held at (0,0) with outputs inactive until the first advance.
  typedef enum logic {
    ST_PARKED = 1'b0,
    ST_RUN    = 1'b1
  } run_state_e;

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis (horizontal or vertical): position counter plus registered
// display-enable and sync derived from the next count value.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL = H_TOTAL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             idle_i,
  input  logic             step_i,
  input  logic [CNT_W-1:0] disp_i,
  input  logic [CNT_W-1:0] fp_i,
  input  logic [CNT_W-1:0] sync_i,
  input  logic             pol_i,
  output logic [CNT_W-1:0] count_o,
  output logic             en_o,
  output logic             sync_o,
  output logic             wrap_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             en_q, en_d;
  logic             act_q, act_d;
  logic [CNT_W:0]   sync_lo, sync_hi;

  assign wrap_o  = step_i && !idle_i && (count_q == LAST);
  assign sync_lo = {1'b0, disp_i} + {1'b0, fp_i};
  assign sync_hi = sync_lo + {1'b0, sync_i};

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    count_d = count_q;
    en_d    = 1'b0;
    act_d   = 1'b0;
    if (idle_i) begin
      count_d = '0;
    end else begin
      if (step_i) begin
        count_d = wrap_o ? '0 : count_q + ONE;
      end
      en_d  = (count_d < disp_i);
      act_d = ({1'b0, count_d} >= sync_lo) && ({1'b0, count_d} < sync_hi);
    end
  end

  // NOTE: async reset in the sensitivity list; state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      en_q    <= 1'b0;
      act_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      en_q    <= en_d;
      act_q   <= act_d;
    end
  end

  // The register holds "sync active"; the polarity tie is a constant, so this is a fixed wire or inverter.
  assign count_o = count_q;
  assign en_o    = en_q;
  assign sync_o  = act_q ^ ~pol_i;

endmodule

// File: rtl/vga_timing_core.sv
// VGA timing generator: pixel-rate divider, h/v axis counters, sync, display enable
// and frame start, all registered and aligned to the counts they accompany.
module vga_timing_core
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int H_DISP  = DEF_H_DISP,
  parameter int H_FP    = DEF_H_FP,
  parameter int H_SYNC  = DEF_H_SYNC,
  parameter int H_BP    = DEF_H_BP,
  parameter int V_DISP  = DEF_V_DISP,
  parameter int V_FP    = DEF_V_FP,
  parameter int V_SYNC  = DEF_V_SYNC,
  parameter int V_BP    = DEF_V_BP,
  parameter bit H_POL   = DEF_H_POL,
  parameter bit V_POL   = DEF_V_POL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             vga_clk,
  output logic             pix_tick,
  output logic [CNT_W-1:0] h_count,
  output logic [CNT_W-1:0] v_count,
  output logic [CNT_W-1:0] h_disp_max,
  output logic [CNT_W-1:0] v_disp_max,
  output logic             h_sync,
  output logic             v_sync,
  output logic             h_en,
  output logic             v_en,
  output logic             frame_start
);

  localparam int H_TOT = axis_total(H_DISP, H_FP, H_SYNC, H_BP);
  localparam int V_TOT = axis_total(V_DISP, V_FP, V_SYNC, V_BP);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W:0]   DIV_HIGH = (DIV_W + 1)'((CLK_DIV + 1) / 2);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             vga_clk_q, vga_clk_d;
  logic             pix_tick_q, pix_tick_d;
  logic             frame_start_q, frame_start_d;
  run_state_e       state_q, state_d;

  logic adv;
  logic axis_idle;
  logic h_step;
  logic h_wrap, v_wrap;

  assign adv = en && (div_cnt_q == DIV_LAST);

  always_comb begin
    div_cnt_d = div_cnt_q + DIV_ONE;
    if (!en || adv) begin
      div_cnt_d = '0;
    end
  end

  // vga_clk is high for the first half (rounded up) of each pixel period.
  assign vga_clk_d  = en && ({1'b0, div_cnt_d} < DIV_HIGH);
  assign pix_tick_d = adv;

  // The first advance out of PARKED loads (0,0) rather than stepping past it.
  always_comb begin
    state_d   = state_q;
    axis_idle = 1'b1;
    h_step    = 1'b0;
    case (state_q)
      ST_PARKED: begin
        if (adv) begin
          state_d   = ST_RUN;
          axis_idle = 1'b0;
        end
      end
      ST_RUN: begin
        if (en) begin
          axis_idle = 1'b0;
          h_step    = adv;
        end else begin
          state_d = ST_PARKED;
        end
      end
      default: state_d = ST_PARKED;
    endcase
  end

  assign frame_start_d = adv && ((state_q == ST_PARKED) || v_wrap);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q     <= '0;
      vga_clk_q     <= 1'b0;
      pix_tick_q    <= 1'b0;
      frame_start_q <= 1'b0;
      state_q       <= ST_PARKED;
    end else begin
      div_cnt_q     <= div_cnt_d;
      vga_clk_q     <= vga_clk_d;
      pix_tick_q    <= pix_tick_d;
      frame_start_q <= frame_start_d;
      state_q       <= state_d;
    end
  end

  vga_axis_counter #(
    .TOTAL (H_TOT)
  ) u_h_axis (
    .clk     (clk),
    .rst     (rst),
    .idle_i  (axis_idle),
    .step_i  (h_step),
    .disp_i  (CNT_W'(H_DISP)),
    .fp_i    (CNT_W'(H_FP)),
    .sync_i  (CNT_W'(H_SYNC)),
    .pol_i   (H_POL),
    .count_o (h_count),
    .en_o    (h_en),
    .sync_o  (h_sync),
    .wrap_o  (h_wrap)
  );

  vga_axis_counter #(
    .TOTAL (V_TOT)
  ) u_v_axis (
    .clk     (clk),
    .rst     (rst),
    .idle_i  (axis_idle),
    .step_i  (h_wrap),
    .disp_i  (CNT_W'(V_DISP)),
    .fp_i    (CNT_W'(V_FP)),
    .sync_i  (CNT_W'(V_SYNC)),
    .pol_i   (V_POL),
    .count_o (v_count),
    .en_o    (v_en),
    .sync_o  (v_sync),
    .wrap_o  (v_wrap)
  );

  assign vga_clk     = vga_clk_q;
  assign pix_tick    = pix_tick_q;
  assign frame_start = frame_start_q;
  assign h_disp_max  = CNT_W'(H_DISP - 1);
  assign v_disp_max  = CNT_W'(V_DISP - 1);

endmodule

// File: tb/tb_vga_timing_core.sv
// Bench for vga_timing_core: default 640x480 instance plus a small CLK_DIV=1 instance,
// both checked every cycle against a behavioural model through an expected-value queue.
module tb_vga_timing_core;

  typedef struct {
    int cdiv;
    int hd, hf, hs, hb;
    int vd, vf, vs, vb;
    bit hpol, vpol;
  } cfg_t;

  typedef struct {
    int div;
    bit run;
    int h, v;
    bit vclk, pix, fs;
  } mst_t;

  typedef struct packed {
    logic        vclk, pix, fs, hs, vs, he, ve;
    logic [10:0] h, v;
  } obs_t;

  logic clk = 1'b0;
  logic rst, en_a, en_b;

  logic        a_vga_clk, a_pix_tick, a_h_sync, a_v_sync, a_h_en, a_v_en, a_frame_start;
  logic [10:0] a_h_count, a_v_count, a_h_disp_max, a_v_disp_max;
  logic        b_vga_clk, b_pix_tick, b_h_sync, b_v_sync, b_h_en, b_v_en, b_frame_start;
  logic [10:0] b_h_count, b_v_count, b_h_disp_max, b_v_disp_max;

  cfg_t cfg_a, cfg_b;
  mst_t ms_a, ms_b;
  obs_t exp_a[$], exp_b[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  vga_timing_core dut_a (
    .clk(clk), .rst(rst), .en(en_a),
    .vga_clk(a_vga_clk), .pix_tick(a_pix_tick),
    .h_count(a_h_count), .v_count(a_v_count),
    .h_disp_max(a_h_disp_max), .v_disp_max(a_v_disp_max),
    .h_sync(a_h_sync), .v_sync(a_v_sync),
    .h_en(a_h_en), .v_en(a_v_en), .frame_start(a_frame_start)
  );

  vga_timing_core #(
    .CLK_DIV(1), .H_DISP(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_POL(1'b1)
  ) dut_b (
    .clk(clk), .rst(rst), .en(en_b),
    .vga_clk(b_vga_clk), .pix_tick(b_pix_tick),
    .h_count(b_h_count), .v_count(b_v_count),
    .h_disp_max(b_h_disp_max), .v_disp_max(b_v_disp_max),
    .h_sync(b_h_sync), .v_sync(b_v_sync),
    .h_en(b_h_en), .v_en(b_v_en), .frame_start(b_frame_start)
  );

  function automatic mst_t m_reset();
    mst_t s;
    s = '{default: 0};
    return s;
  endfunction

  function automatic mst_t m_next(input cfg_t c, input mst_t s, input bit e);
    mst_t n = s;
    int htot = c.hd + c.hf + c.hs + c.hb;
    int vtot = c.vd + c.vf + c.vs + c.vb;
    if (!e) return m_reset();
    n.fs  = 1'b0;
    n.pix = (s.div == c.cdiv - 1);
    n.div = n.pix ? 0 : s.div + 1;
    if (n.pix) begin
      if (!s.run) begin
        n.run = 1'b1; n.h = 0; n.v = 0; n.fs = 1'b1;
      end else begin
        n.h = s.h + 1;
        if (n.h == htot) begin
          n.h = 0;
          n.v = s.v + 1;
          if (n.v == vtot) begin
            n.v = 0; n.fs = 1'b1;
          end
        end
      end
    end
    n.vclk = (n.div < (c.cdiv + 1) / 2);
    return n;
  endfunction

  function automatic obs_t m_obs(input cfg_t c, input mst_t s);
    obs_t o;
    o.vclk = s.vclk;
    o.pix  = s.pix;
    o.fs   = s.fs;
    o.h    = 11'(s.h);
    o.v    = 11'(s.v);
    o.he   = s.run && (s.h < c.hd);
    o.ve   = s.run && (s.v < c.vd);
    o.hs   = (s.run && s.h >= c.hd + c.hf && s.h < c.hd + c.hf + c.hs) ? c.hpol : !c.hpol;
    o.vs   = (s.run && s.v >= c.vd + c.vf && s.v < c.vd + c.vf + c.vs) ? c.vpol : !c.vpol;
    return o;
  endfunction

  // One clock: push model expectations at the edge, pop and compare half a cycle later.
  task automatic tick();
    obs_t ga, gb, ea, eb;
    @(posedge clk);
    if (rst) begin
      ms_a = m_reset();
      ms_b = m_reset();
    end else begin
      ms_a = m_next(cfg_a, ms_a, en_a);
      ms_b = m_next(cfg_b, ms_b, en_b);
    end
    exp_a.push_back(m_obs(cfg_a, ms_a));
    exp_b.push_back(m_obs(cfg_b, ms_b));
    @(negedge clk);
    ga = {a_vga_clk, a_pix_tick, a_frame_start, a_h_sync, a_v_sync, a_h_en, a_v_en, a_h_count, a_v_count};
    gb = {b_vga_clk, b_pix_tick, b_frame_start, b_h_sync, b_v_sync, b_h_en, b_v_en, b_h_count, b_v_count};
    ea = exp_a.pop_front();
    eb = exp_b.pop_front();
    checks += 2;
    if (ga !== ea) begin
      errors++;
      if (errors <= 20)
        $display("FAIL scoreboard_a @%0t: got h=%0d v=%0d flags=%b, expected h=%0d v=%0d flags=%b",
                 $time, ga.h, ga.v, ga[28:22], ea.h, ea.v, ea[28:22]);
    end
    if (gb !== eb) begin
      errors++;
      if (errors <= 20)
        $display("FAIL scoreboard_b @%0t: got h=%0d v=%0d flags=%b, expected h=%0d v=%0d flags=%b",
                 $time, gb.h, gb.v, gb[28:22], eb.h, eb.v, eb[28:22]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; en_a = 1'b0; en_b = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({a_h_count, a_v_count} !== 22'd0) begin
      errors++; $display("FAIL reset_counts: got h=%0d v=%0d, expected 0 0", a_h_count, a_v_count);
    end
    checks++;
    if ({a_vga_clk, a_pix_tick, a_frame_start, a_h_en, a_v_en} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b, expected 00000",
               {a_vga_clk, a_pix_tick, a_frame_start, a_h_en, a_v_en});
    end
    checks++;
    if ({a_h_sync, a_v_sync, b_h_sync, b_v_sync} !== 4'b1110) begin
      errors++;
      $display("FAIL reset_sync: got %b, expected 1110", {a_h_sync, a_v_sync, b_h_sync, b_v_sync});
    end
    checks++;
    if ({a_h_disp_max, a_v_disp_max, b_h_disp_max, b_v_disp_max} !== {11'd639, 11'd479, 11'd7, 11'd479}) begin
      errors++;
      $display("FAIL disp_max: got %0d %0d %0d %0d, expected 639 479 7 479",
               a_h_disp_max, a_v_disp_max, b_h_disp_max, b_v_disp_max);
    end
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_pixel_rate();
    int starts = 0, last = 0, pix = 0, hmax = 0;
    en_a = 1'b1;
    for (int i = 0; i < 6000 && starts < 4; i++) begin
      tick();
      if (a_pix_tick && a_h_count == 11'd0) begin
        if (starts > 0) begin
          checks++;
          if (i - last != 1600) begin
            errors++; $display("FAIL line_period: got %0d clk, expected 1600", i - last);
          end
        end
        starts++;
        last = i;
      end
      if (starts >= 1 && starts <= 3) begin
        pix += int'(a_pix_tick);
        if (int'(a_h_count) > hmax) hmax = int'(a_h_count);
      end
    end
    checks++;
    if (starts != 4) begin
      errors++; $display("FAIL line_timeout: got %0d line starts, expected 4", starts);
    end
    checks++;
    if (pix != 2400) begin
      errors++; $display("FAIL pix_tick_rate: got %0d ticks in 3 lines, expected 2400", pix);
    end
    checks++;
    if (hmax != 799) begin
      errors++; $display("FAIL h_max: got %0d, expected 799", hmax);
    end
  endtask

  task automatic test_h_window();
    int sync_cyc = 0, en_cyc = 0, smin = 2047, smax = -1, emax = -1;
    for (int i = 0; i < 1600; i++) begin
      tick();
      if (!a_h_sync) begin
        sync_cyc++;
        if (int'(a_h_count) < smin) smin = int'(a_h_count);
        if (int'(a_h_count) > smax) smax = int'(a_h_count);
      end
      if (a_h_en) begin
        en_cyc++;
        if (int'(a_h_count) > emax) emax = int'(a_h_count);
      end
    end
    checks++;
    if (sync_cyc != 192 || smin != 656 || smax != 751) begin
      errors++;
      $display("FAIL h_sync_window: got %0d clk over h %0d..%0d, expected 192 clk over 656..751",
               sync_cyc, smin, smax);
    end
    checks++;
    if (en_cyc != 1280 || emax != 639) begin
      errors++;
      $display("FAIL h_en_window: got %0d clk up to h %0d, expected 1280 clk up to 639", en_cyc, emax);
    end
  endtask

  task automatic test_en_drop();
    bit found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      tick();
      found = (a_h_count == 11'd300);
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL en_drop_timeout: h=300 not reached, last h=%0d", a_h_count);
    end
    en_a = 1'b0;
    tick();
    checks++;
    if ({a_h_count, a_v_count, a_h_sync, a_v_sync, a_h_en, a_v_en, a_pix_tick, a_vga_clk} !== {22'd0, 6'b110000}) begin
      errors++;
      $display("FAIL en_drop_park: got h=%0d v=%0d sync=%b%b en=%b%b pix=%b vclk=%b, expected 0 0 11 00 0 0",
               a_h_count, a_v_count, a_h_sync, a_v_sync, a_h_en, a_v_en, a_pix_tick, a_vga_clk);
    end
    repeat (3) tick();
    en_a = 1'b1;
    tick();
    checks++;
    if (a_frame_start !== 1'b0) begin
      errors++; $display("FAIL en_restart_early: got frame_start=%b, expected 0", a_frame_start);
    end
    tick();
    checks++;
    if ({a_frame_start, a_pix_tick, a_h_en, a_h_count} !== {3'b111, 11'd0}) begin
      errors++;
      $display("FAIL en_restart_frame: got fs=%b pix=%b h_en=%b h=%0d, expected 1 1 1 0",
               a_frame_start, a_pix_tick, a_h_en, a_h_count);
    end
  endtask

  task automatic test_async_reset();
    bit found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      tick();
      found = (a_h_count == 11'd700);
    end
    checks++;
    if (!found || a_h_sync !== 1'b0) begin
      errors++; $display("FAIL async_setup: got h=%0d h_sync=%b, expected 700 0", a_h_count, a_h_sync);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({a_h_sync, a_h_count, a_v_count, a_h_en} !== {1'b1, 22'd0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: got h_sync=%b h=%0d v=%0d h_en=%b, expected 1 0 0 0",
               a_h_sync, a_h_count, a_v_count, a_h_en);
    end
    tick();
    en_a = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_small_frame();
    int fs = 0, last = 0, vs_cyc = 0, vsmin = 2047, vsmax = -1, vmax = 0, nopix = 0;
    bit found = 1'b0;
    en_b = 1'b1;
    for (int i = 0; i < 16000 && fs < 3; i++) begin
      tick();
      if (b_frame_start) begin
        if (fs > 0) begin
          checks++;
          if (i - last != 7350) begin
            errors++; $display("FAIL frame_period: got %0d clk, expected 7350", i - last);
          end
        end
        fs++;
        last = i;
      end
      if (fs >= 1 && fs <= 2) begin
        nopix += int'(!b_pix_tick);
        if (int'(b_v_count) > vmax) vmax = int'(b_v_count);
        if (b_v_sync) begin
          vs_cyc++;
          if (int'(b_v_count) < vsmin) vsmin = int'(b_v_count);
          if (int'(b_v_count) > vsmax) vsmax = int'(b_v_count);
        end
      end
    end
    checks++;
    if (fs != 3) begin
      errors++; $display("FAIL frame_timeout: got %0d frame starts, expected 3", fs);
    end
    checks++;
    if (vs_cyc != 56 || vsmin != 490 || vsmax != 491) begin
      errors++;
      $display("FAIL v_sync_window: got %0d clk over v %0d..%0d, expected 56 clk over 490..491",
               vs_cyc, vsmin, vsmax);
    end
    checks++;
    if (vmax != 524 || nopix != 0) begin
      errors++; $display("FAIL small_frame: got vmax=%0d idle_ticks=%0d, expected 524 0", vmax, nopix);
    end
    for (int i = 0; i < 3000 && !found; i++) begin
      tick();
      found = (b_v_count == 11'd200 && b_h_count == 11'd5);
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL small_drop_timeout: got h=%0d v=%0d, expected 5 200", b_h_count, b_v_count);
    end
    en_b = 1'b0;
    tick();
    checks++;
    if ({b_h_count, b_v_count, b_h_sync, b_v_sync, b_pix_tick} !== {22'd0, 3'b100}) begin
      errors++;
      $display("FAIL small_drop_park: got h=%0d v=%0d h_sync=%b v_sync=%b pix=%b, expected 0 0 1 0 0",
               b_h_count, b_v_count, b_h_sync, b_v_sync, b_pix_tick);
    end
    en_b = 1'b1;
    tick();
    checks++;
    if ({b_frame_start, b_h_en, b_h_count} !== {2'b11, 11'd0}) begin
      errors++;
      $display("FAIL small_restart: got fs=%b h_en=%b h=%0d, expected 1 1 0", b_frame_start, b_h_en, b_h_count);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 400; i++) begin
      en_a = ($urandom_range(0, 7) != 0);
      en_b = ($urandom_range(0, 3) != 0);
      tick();
    end
    en_a = 1'b0;
    en_b = 1'b0;
    tick();
  endtask

  initial begin
    cfg_a = '{cdiv: 2, hd: 640, hf: 16, hs: 96, hb: 48, vd: 480, vf: 10, vs: 2, vb: 33, hpol: 1'b0, vpol: 1'b0};
    cfg_b = '{cdiv: 1, hd: 8, hf: 2, hs: 2, hb: 2, vd: 480, vf: 10, vs: 2, vb: 33, hpol: 1'b0, vpol: 1'b1};
    ms_a = m_reset();
    ms_b = m_reset();
    test_reset();
    test_pixel_rate();
    test_h_window();
    test_en_drop();
    test_async_reset();
    test_small_frame();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
